// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register.
// Keeps the PC, drives an instruction-memory request/ready handshake and
// presents the fetched word plus PC+4 to decode. Jumps and taken branches
// from decode redirect the PC and turn the IF/ID slot into a bubble.
// A response that arrives while decode is stalled is parked in a one-entry
// skid buffer. A request abandoned by a redirect is drained in DROP.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Jump,
  input  logic        PCFromReg,
  input  logic [31:0] RegTarget,
  input  logic        BranchTaken,
  input  logic [15:0] BranchOffset,
  output logic [31:0] IMemAddr,
  output logic        IMemRE,
  input  logic [31:0] IMemData,
  input  logic        IMemReady,
  output logic [31:0] Instruction,
  output logic [31:0] PCPlus4Out,
  output logic        InstValid
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DROP  = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      stateReg, stateNext;
  logic [31:0] pcReg, pcNext;
  logic [31:0] dropAddrReg, dropAddrNext;
  logic [31:0] skidInstReg, skidInstNext;
  logic [31:0] skidPc4Reg, skidPc4Next;
  logic [31:0] instReg, instNext;
  logic [31:0] pc4Reg, pc4Next;
  logic        validReg, validNext;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pcPlus4;
  logic [31:0] branchDisp;

  assign redirect   = Jump | BranchTaken;
  assign pcPlus4    = pcReg + 32'd4;
  assign branchDisp = {{14{BranchOffset[15]}}, BranchOffset, 2'b00};

  // Redirect target: register jump, then pseudo-direct jump, then branch.
  always_comb begin
    target = pc4Reg + branchDisp;
    if (Jump && PCFromReg) begin
      target = RegTarget;
    end else if (Jump) begin
      target = {pc4Reg[31:28], instReg[25:0], 2'b00};
    end
  end

  // Next-state and IF/ID update; a redirect always wins over a stall.
  always_comb begin
    stateNext    = stateReg;
    pcNext       = pcReg;
    dropAddrNext = dropAddrReg;
    skidInstNext = skidInstReg;
    skidPc4Next  = skidPc4Reg;
    instNext     = instReg;
    pc4Next      = pc4Reg;
    validNext    = validReg;

    if (redirect) begin
      instNext  = 32'd0;
      validNext = 1'b0;
      pcNext    = target;
    end

    case (stateReg)
      FETCH: begin
        if (IMemReady) begin
          if (redirect) begin
            stateNext = FETCH;
          end else if (Stall) begin
            skidInstNext = IMemData;
            skidPc4Next  = pcPlus4;
            pcNext       = pcPlus4;
            stateNext    = HOLD;
          end else begin
            instNext  = IMemData;
            pc4Next   = pcPlus4;
            validNext = 1'b1;
            pcNext    = pcPlus4;
          end
        end else if (redirect) begin
          // Keep presenting the old address until its response shows up.
          dropAddrNext = pcReg;
          stateNext    = DROP;
        end else if (!Stall) begin
          instNext  = 32'd0;
          validNext = 1'b0;
        end
      end
      DROP: begin
        if (IMemReady) begin
          stateNext = FETCH;
        end
        if (!redirect && !Stall) begin
          instNext  = 32'd0;
          validNext = 1'b0;
        end
      end
      HOLD: begin
        if (redirect) begin
          stateNext = FETCH;
        end else if (!Stall) begin
          instNext  = skidInstReg;
          pc4Next   = skidPc4Reg;
          validNext = 1'b1;
          stateNext = FETCH;
        end
      end
      default: begin
        stateNext = FETCH;
      end
    endcase
  end

  // State, PC, skid buffer and IF/ID register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      stateReg    <= FETCH;
      pcReg       <= RESET_PC;
      dropAddrReg <= 32'd0;
      skidInstReg <= 32'd0;
      skidPc4Reg  <= 32'd0;
      instReg     <= 32'd0;
      pc4Reg      <= 32'd0;
      validReg    <= 1'b0;
    end else begin
      stateReg    <= stateNext;
      pcReg       <= pcNext;
      dropAddrReg <= dropAddrNext;
      skidInstReg <= skidInstNext;
      skidPc4Reg  <= skidPc4Next;
      instReg     <= instNext;
      pc4Reg      <= pc4Next;
      validReg    <= validNext;
    end
  end

  assign IMemRE      = (stateReg != HOLD);
  assign IMemAddr    = (stateReg == DROP) ? dropAddrReg : pcReg;
  assign Instruction = instReg;
  assign PCPlus4Out  = pc4Reg;
  assign InstValid   = validReg;

endmodule
